// File: rtl/keypad_scan_ctrl.sv
// Column-scanning 3x4 keypad controller: debounced snapshot per frame, one event per press over valid/ready.
// Optional auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV      = 1000,
   parameter int DEBOUNCE_CNT  = 4,
   parameter int REPEAT_FRAMES = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [2:0]  col_out,
   output logic        key_valid,
   input  logic        key_ready,
   output logic [3:0]  key_code,
   output logic [11:0] key_onehot,
   output logic        overrun
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int STB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0] STB_MAX   = STB_W'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_MULTI} state_t;

   logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [CNT_W-1:0] slot_q, slot_d;
   logic [2:0]       col_q, col_d;
   logic [11:0]      snap_q, snap_d, prev_q, prev_d;
   logic [STB_W-1:0] stable_q, stable_d;
   state_t           state_q, state_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic [11:0]      key_onehot_q, key_onehot_d;
   logic             overrun_q, overrun_d;

   logic        tick, frame_end, accept, xfer, emit, single;
   logic [1:0]  col_idx;
   logic [11:0] snap_full;
   logic [3:0]  enc, emit_code;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = (REPEAT_FRAMES > 2) ? $clog2(REPEAT_FRAMES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
   logic [REP_W-1:0] rep_q, rep_d;
   logic [3:0]       held_code_q, held_code_d;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_FRAMES > 0);
`endif

   always_comb begin
      row_s1_d     = row_in;
      row_s2_d     = row_s1_q;
      slot_d       = slot_q;
      col_d        = col_q;
      snap_d       = snap_q;
      prev_d       = prev_q;
      stable_d     = stable_q;
      state_d      = state_q;
      key_valid_d  = key_valid_q;
      key_code_d   = key_code_q;
      key_onehot_d = key_onehot_q;
      overrun_d    = overrun_q;
      accept       = 1'b0;
      emit         = 1'b0;
      emit_code    = 4'd0;
      enc          = 4'd0;

      tick      = (slot_q == SLOT_LAST);
      slot_d    = tick ? '0 : slot_q + CNT_W'(1);
      frame_end = tick && col_q[2];
      case (col_q)
         3'b001:  col_idx = 2'd0;
         3'b010:  col_idx = 2'd1;
         default: col_idx = 2'd2;
      endcase

      // Snapshot with the active column's rows merged in; complete at column 2's tick.
      snap_full = snap_q;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (col_idx == 2'(c)) snap_full[r*3+c] = row_s2_q[r];
         end
      end
      single = $onehot(snap_full);
      for (int i = 0; i < 12; i++) begin
         if (snap_full[i]) enc = 4'(i);
      end

      if (tick) begin
         snap_d = snap_full;
         col_d  = {col_q[1:0], col_q[2]};
      end

      if (frame_end) begin
         prev_d = snap_full;
         if (snap_full != prev_q)    stable_d = STB_W'(1);
         else if (stable_q != STB_MAX) stable_d = stable_q + STB_W'(1);
         accept = (stable_d == STB_MAX) && ((snap_full != prev_q) || (stable_q != STB_MAX));
      end

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (single) begin
                  emit      = 1'b1;
                  emit_code = enc;
                  state_d   = ST_HELD;
               end else if (snap_full != 12'd0) begin
                  state_d = ST_MULTI;
               end
            end
            ST_HELD:  if (snap_full == 12'd0) state_d = ST_IDLE;
            default:  if (snap_full == 12'd0) state_d = ST_IDLE;
         endcase
      end

`ifdef KEYPAD_REPEAT_EN
      rep_d       = rep_q;
      held_code_d = emit ? enc : held_code_q;
      // Count only frames that still debounce to the same single key.
      if (frame_end && state_q == ST_HELD && state_d == ST_HELD &&
          stable_d == STB_MAX && snap_full == (12'd1 << held_code_q)) begin
         if (rep_q == REP_LAST) begin
            emit      = 1'b1;
            emit_code = held_code_q;
            rep_d     = '0;
         end else begin
            rep_d = rep_q + REP_W'(1);
         end
      end
      if (state_d != state_q) rep_d = '0;
`endif

      xfer = key_valid_q && key_ready;
      if (xfer) key_valid_d = 1'b0;
      if (emit) begin
         if (!key_valid_q || xfer) begin
            key_valid_d  = 1'b1;
            key_code_d   = emit_code;
            key_onehot_d = 12'd1 << emit_code;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1_q     <= '0;
         row_s2_q     <= '0;
         slot_q       <= '0;
         col_q        <= 3'b001;
         snap_q       <= '0;
         prev_q       <= '0;
         stable_q     <= '0;
         state_q      <= ST_IDLE;
         key_valid_q  <= 1'b0;
         key_code_q   <= '0;
         key_onehot_q <= '0;
         overrun_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q        <= '0;
         held_code_q  <= '0;
`endif
      end else begin
         row_s1_q     <= row_s1_d;
         row_s2_q     <= row_s2_d;
         slot_q       <= slot_d;
         col_q        <= col_d;
         snap_q       <= snap_d;
         prev_q       <= prev_d;
         stable_q     <= stable_d;
         state_q      <= state_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         key_onehot_q <= key_onehot_d;
         overrun_q    <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q        <= rep_d;
         held_code_q  <= held_code_d;
`endif
      end
   end

   assign col_out    = col_q;
   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign key_onehot = key_onehot_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, directed press sequences, event scoreboard.
module tb_keypad_scan_ctrl;
   localparam int SD = 4, DB = 2, RF = 3;
   localparam int FRAME = 3 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_in;
   logic [2:0]  col_out;
   logic        key_valid;
   logic        key_ready = 1'b1;
   logic [3:0]  key_code;
   logic [11:0] key_onehot;
   logic        overrun;
   logic [11:0] keys = 12'd0;

   int checks = 0;
   int failures = 0;
   int events = 0;
   int e0;
   logic [3:0] exp_q[$];

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_FRAMES(RF)) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
      .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
      .key_onehot(key_onehot), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // A pressed key connects its column line to its row line.
   assign row_in = {|(keys[11:9] & col_out), |(keys[8:6] & col_out),
                    |(keys[5:3] & col_out),  |(keys[2:0] & col_out)};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && key_valid && key_ready) begin
         logic [3:0] exp_code;
         events++;
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_code = exp_q.pop_front();
            check("ev_code", 32'(key_code), 32'(exp_code));
            check("ev_onehot", 32'(key_onehot), 32'(12'd1 << exp_code));
         end
      end
   end

   initial begin
      // Reset
      cyc(3);
      check("rst_col", 32'(col_out), 32'b001);
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_onehot", 32'(key_onehot), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      cyc(3);
      check("col_hold", 32'(col_out), 32'b001);
      cyc(1);
      check("col_rot", 32'(col_out), 32'b010);
      cyc(4 * FRAME);

      // Clean press of key 5
      e0 = events;
      exp_q.push_back(4'd5);
      keys = 12'd1 << 5;
      cyc(4 * FRAME);
      keys = 12'd0;
      cyc(4 * FRAME);
      check("clean_count", 32'(events), 32'(e0 + 1));
      check("clean_code_hold", 32'(key_code), 32'd5);
      check("clean_onehot_hold", 32'(key_onehot), 32'h020);

      // Bouncing key 7
      e0 = events;
      for (int i = 0; i < 4; i++) begin
         keys = (i % 2 == 0) ? (12'd1 << 7) : 12'd0;
         cyc(FRAME);
      end
      check("bounce_none", 32'(events), 32'(e0));
      exp_q.push_back(4'd7);
      keys = 12'd1 << 7;
      cyc(FRAME);
      check("bounce_early", 32'(events), 32'(e0));
      cyc(2 * FRAME);
      check("bounce_count", 32'(events), 32'(e0 + 1));
      keys = 12'd0;
      cyc(4 * FRAME);

      // Overrun: key 0 held unconsumed, key 11 dropped
      e0 = events;
      key_ready = 1'b0;
      exp_q.push_back(4'd0);
      keys = 12'd1 << 0;
      cyc(4 * FRAME);
      keys = 12'd0;
      cyc(4 * FRAME);
      check("ovr_no_overrun_yet", 32'(overrun), 32'd0);
      keys = 12'd1 << 11;
      cyc(4 * FRAME);
      check("ovr_valid", 32'(key_valid), 32'd1);
      check("ovr_code", 32'(key_code), 32'd0);
      check("ovr_flag", 32'(overrun), 32'd1);
      keys = 12'd0;
      cyc(4 * FRAME);
      key_ready = 1'b1;
      cyc(1);
      check("ovr_valid_drop", 32'(key_valid), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'd1);
      check("ovr_count", 32'(events), 32'(e0 + 1));

      // Multi-key 1+4, then key 4 alone
      e0 = events;
      keys = (12'd1 << 1) | (12'd1 << 4);
      cyc(4 * FRAME);
      keys = 12'd0;
      cyc(4 * FRAME);
      check("multi_none", 32'(events), 32'(e0));
      exp_q.push_back(4'd4);
      keys = 12'd1 << 4;
      cyc(4 * FRAME);
      keys = 12'd0;
      cyc(4 * FRAME);
      check("multi_then_single", 32'(events), 32'(e0 + 1));

      // Long hold of key 9
      e0 = events;
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(4'd9);
`else
      exp_q.push_back(4'd9);
`endif
      keys = 12'd1 << 9;
      cyc(12 * FRAME);
      keys = 12'd0;
      cyc(4 * FRAME);
`ifdef KEYPAD_REPEAT_EN
      check("hold_count", 32'(events), 32'(e0 + 4));
`else
      check("hold_count", 32'(events), 32'(e0 + 1));
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      check("final_overrun", 32'(overrun), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
